pipeline_elastic_fd: RTL

- Next-generation Fetch->Decode pipeline register: parametrised widths, valid/ready handshake, 2-entry skid buffer, flush with NOP injection, bubble counter.
- Sits between the fetch stage (PC/instruction memory) and the decode stage (register file/control) in the pipelined core.
- Replaces the unconditional F/D latch so hazard logic can stall (deassert out_ready_i) and squash (flush_i) without losing or duplicating instructions.

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/pipeline_elastic_fd.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline-register types: payload layout, handshake states and the bubble instruction.
package pipeline_pkg;

  localparam int unsigned FD_XLEN = 32;
  localparam int unsigned FD_ILEN = 32;

  // addi x0,x0,0
  localparam logic [FD_ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FD_ILEN-1:0] instr;
    logic [FD_XLEN-1:0] pc;
    logic [FD_XLEN-1:0] pcplus4;
  } fd_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } fd_state_t;

  function automatic fd_payload_t nop_payload();
    fd_payload_t p;
    p.instr   = NOP_INSTR;
    p.pc      = {FD_XLEN{1'b0}};
    p.pcplus4 = {FD_XLEN{1'b0}};
    return p;
  endfunction

endpackage

// File: rtl/pipeline_elastic_fd.sv
// Elastic Fetch->Decode register: valid/ready handshake with a one-entry skid slot behind
// the main register, flush with NOP injection and a saturating bubble counter.
module pipeline_elastic_fd
  import pipeline_pkg::*;
#(
  parameter int unsigned       XLEN      = 32,
  parameter int unsigned       ILEN      = 32,
  parameter logic [ILEN-1:0]   NOP_INSTR = pipeline_pkg::NOP_INSTR,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [ILEN-1:0]  InstrF_i,
  input  logic [XLEN-1:0]  PCF_i,
  input  logic [XLEN-1:0]  PCPlus4F_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ILEN-1:0]  InstrD_o,
  output logic [XLEN-1:0]  PCD_o,
  output logic [XLEN-1:0]  PCPlus4D_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  fd_state_t   state_r, state_n;
  fd_payload_t main_r, main_n;
  fd_payload_t skid_r, skid_n;
  logic        skid_vld_r, skid_vld_n;
  logic        out_valid_r, in_ready_r;
  logic [CNT_W-1:0] bubble_cnt_r;

  fd_payload_t nop_beat;
  fd_payload_t in_beat;
  logic        accept, take;

  always_comb begin
    nop_beat       = nop_payload();
    nop_beat.instr = NOP_INSTR;
  end

  assign in_beat = '{instr: InstrF_i, pc: PCF_i, pcplus4: PCPlus4F_i};
  assign accept  = in_valid_i & in_ready_r;
  assign take    = out_valid_r & out_ready_i;

  // Next-state and datapath selection; flush overrides every handshake outcome.
  always_comb begin
    state_n    = state_r;
    main_n     = main_r;
    skid_n     = skid_r;
    skid_vld_n = skid_vld_r;
    if (flush_i) begin
      state_n    = EMPTY;
      main_n     = nop_beat;
      skid_vld_n = 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept) begin
            state_n = BUSY;
            main_n  = in_beat;
          end else begin
            state_n = EMPTY;
          end
        end
        BUSY: begin
          if (accept && take) begin
            main_n = in_beat;
          end else if (accept) begin
            state_n    = FULL;
            skid_n     = in_beat;
            skid_vld_n = 1'b1;
          end else if (take) begin
            state_n = EMPTY;
            main_n  = nop_beat;
          end else begin
            state_n = BUSY;
          end
        end
        FULL: begin
          if (take) begin
            state_n    = BUSY;
            main_n     = skid_r;
            skid_vld_n = 1'b0;
          end else begin
            state_n = FULL;
          end
        end
        default: begin
          state_n    = EMPTY;
          main_n     = nop_beat;
          skid_vld_n = 1'b0;
        end
      endcase
    end
  end

  // State, payload registers and handshake flags, all derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      main_r      <= nop_beat;
      skid_r      <= '0;
      skid_vld_r  <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_n;
      main_r      <= main_n;
      skid_r      <= skid_n;
      skid_vld_r  <= skid_vld_n;
      out_valid_r <= (state_n != EMPTY);
      in_ready_r  <= (state_n != FULL);
    end
  end

  // Saturating count of cycles with no valid instruction presented to decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (!out_valid_r && (bubble_cnt_r != {CNT_W{1'b1}})) begin
      bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign in_ready_o   = in_ready_r;
  assign out_valid_o  = out_valid_r;
  assign InstrD_o     = main_r.instr;
  assign PCD_o        = main_r.pc;
  assign PCPlus4D_o   = main_r.pcplus4;
  assign bubble_cnt_o = bubble_cnt_r;

endmodule
